regfile_access_sequencer: RTL and testbench
===========================================

# regfile_access_sequencer

Initiator-side sequencer that owns the single command port of the 32x32 `register_file`. It accepts independent operand-read requests (two sources) and write-back requests (one destination) from the datapath. Writes are queued in a small write buffer, and reads that hit a queued destination are held back. Every cycle it issues at most one registered command (read, write or clear) to the register file and returns read data with fixed latency.

## Interface

Parameters:
- `WB_DEPTH`, 4: write-buffer entries (power of two, ≥2).
- `DATA_WIDTH`, 32: register width.
- `ADDR_WIDTH`, 5: register index width.

Ports (all sampled/driven on `clock`):
- `clock` input 1: single clock.
- `reset` input 1: synchronous, active-high.
- `rd_req_valid` input 1: read request present.
- `rd_req_ready` output 1: read accepted this edge when both high.
- `rd_src1`, `rd_src2` input ADDR_WIDTH: source indices.
- `rd_resp_valid` output 1: one-cycle pulse, read data valid (no backpressure).
- `rd_data1`, `rd_data2` output DATA_WIDTH: read data.
- `wr_req_valid` input 1: write request present.
- `wr_req_ready` output 1: write accepted into buffer when both high.
- `wr_dst` input ADDR_WIDTH: destination index.
- `wr_data` input DATA_WIDTH: write data.
- `clear_req` input 1: request to zero the whole register file.
- `clear_ack` output 1: one-cycle pulse, clear complete.
- `wb_count` output clog2(WB_DEPTH)+1: buffered writes pending.
- `rf_in` output DATA_WIDTH: to register file `in`.
- `rf_select_input` output ADDR_WIDTH: to register file `select_input`.
- `rf_select_output_1`, `rf_select_output_2` output ADDR_WIDTH: to register file read selects.
- `rf_read`, `rf_write`, `rf_enable`, `rf_reset` output 1: to register file controls.
- `rf_data_1`, `rf_data_2` input DATA_WIDTH: from register file `data_1`/`data_2`.

## Operation

- Reset: state RUN, buffer empty. `wb_count`=0. All `rf_*` outputs, `rd_resp_valid` and `clear_ack` are 0. `wr_req_ready` is 1 once reset deasserts.
- State RUN. Each edge, exactly one command is selected and registered onto the `rf_*` outputs for the next cycle. Priority:
  1. `clear_req` high: go to CLEAR.
  2. Buffer full: pop and issue the oldest write.
  3. Read request with no hazard: issue the read.
  4. Buffer non-empty: pop and issue the oldest write.
  5. Otherwise idle. All `rf_read`/`rf_write`/`rf_enable`/`rf_reset` are 0.
- `rf_enable` = `rf_read` | `rf_write` | `rf_reset`. Never more than one of `rf_read`, `rf_write`, `rf_reset` is high in a cycle. This matters because the register file gives read priority over write.
- Hazard: `rd_src1` or `rd_src2` equals `wr_dst` of any valid buffer entry, compared against buffer contents before the edge.
- `rd_req_ready` = RUN & !clear_req & !full & !hazard. Acceptance and issue of a read occur on the same edge.
- Same-cycle ordering: a write accepted on the same edge as a read is ordered after that read, so the read returns the old value.
- Write buffer is a FIFO. `wr_req_ready` = RUN & (`wb_count` < WB_DEPTH). Push and pop on the same edge leaves the count unchanged. Writes are issued strictly in arrival order, and duplicate destinations are allowed.
- Index 0 is an ordinary register; there is no hard-wiring.
- CLEAR:
  - Entry edge: discard all buffered writes (`wb_count`→0). Drive `rf_reset`=`rf_enable`=1 for one cycle.
  - Next edge: go to CLEAR_DONE and pulse `clear_ack`.
  - Next edge: return to RUN.
  - `rd_req_ready` and `wr_req_ready` are 0 in CLEAR and CLEAR_DONE.
  - A read already issued before CLEAR still returns its response.
- `reset` asserted mid-operation: the buffer is discarded and any in-flight `rd_resp_valid` is suppressed. The register-file contents are not touched.

## Timing

- Read: accepted at edge E0, `rf_read` high in cycle E0..E1, register file captures at E1. `rd_resp_valid` is high in cycle E1..E2; it is a registered copy of `rf_read`.
- `rd_data1`/`rd_data2` pass through combinationally from `rf_data_1`/`rf_data_2`. They are only meaningful while `rd_resp_valid`=1.
- Read latency is 2 edges from acceptance. Throughput is one read per cycle when no writes are pending.
- Write: pushed at E0, earliest issue at E1 (`rf_write` high E1..E2), committed in the register file at E2. A read accepted at or after E2 sees the new value.
- `clear_ack` is high in the third cycle after `clear_req` is sampled.

## Test plan

- Reset then read r3,r7: `rd_resp_valid` is high exactly 2 cycles after acceptance, with data1=data2=0.
- Write r5=0xDEADBEEF, then read r5,r0 on the next cycle: the read stalls (ready=0) until the write is issued, then returns 0xDEADBEEF and 0.
- Five back-to-back writes to r1..r5 with `rd_req_valid` held on r9: the buffer fills to 4, `wr_req_ready` drops, and writes drain with priority. Reads resume, and a final read of r1..r5 returns the written values in order.
- Read and write both to r2 on the same edge, with r2 previously 0x11 and new 0x22: the read returns 0x11, and a later read returns 0x22.
- Queue 3 writes, then raise `clear_req`: `wb_count`→0, `rf_reset` pulses once, `clear_ack` arrives 3 cycles later, and all registers read 0.
- Assert `reset` with 2 writes queued and one read in flight: no `rd_resp_valid`, `wb_count`=0, and the queued writes never reach the register file.

Source files
------------

// File: rtl/regfile_access_sequencer.sv
// Sequences reads, buffered writes and clears onto the single register-file command port.
// Read data returns 2 edges after acceptance; reads stall on a full buffer or on a pending write hazard.
module regfile_access_sequencer #(
  parameter int WB_DEPTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rd_req_valid,
  output logic                          rd_req_ready,
  input  logic [ADDR_WIDTH-1:0]         rd_src1,
  input  logic [ADDR_WIDTH-1:0]         rd_src2,
  output logic                          rd_resp_valid,
  output logic [DATA_WIDTH-1:0]         rd_data1,
  output logic [DATA_WIDTH-1:0]         rd_data2,
  input  logic                          wr_req_valid,
  output logic                          wr_req_ready,
  input  logic [ADDR_WIDTH-1:0]         wr_dst,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          clear_req,
  output logic                          clear_ack,
  output logic [$clog2(WB_DEPTH):0]     wb_count,
  output logic [DATA_WIDTH-1:0]         rf_in,
  output logic [ADDR_WIDTH-1:0]         rf_select_input,
  output logic [ADDR_WIDTH-1:0]         rf_select_output_1,
  output logic [ADDR_WIDTH-1:0]         rf_select_output_2,
  output logic                          rf_read,
  output logic                          rf_write,
  output logic                          rf_enable,
  output logic                          rf_reset,
  input  logic [DATA_WIDTH-1:0]         rf_data_1,
  input  logic [DATA_WIDTH-1:0]         rf_data_2
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {RUN, CLEAR, CLEAR_DONE} state_t;
  typedef enum logic [1:0] {CMD_IDLE, CMD_READ, CMD_WRITE, CMD_CLEAR} cmd_t;

  state_t state_q, state_d;
  cmd_t   cmd_d;

  logic [ADDR_WIDTH-1:0] wb_dst_q [WB_DEPTH];
  logic [DATA_WIDTH-1:0] wb_dat_q [WB_DEPTH];
  logic [WB_DEPTH-1:0]   wb_vld_q;
  logic [PW-1:0]         head_q, tail_q;
  logic [CW-1:0]         count_q;

  logic full, empty, hazard, run;
  logic push, pop, flush, rd_go;

  assign full  = (count_q == CW'(WB_DEPTH));
  assign empty = (count_q == '0);
  assign run   = (state_q == RUN);

  // Hazard looks at every live entry, not just the head, since any of them may alias a source.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (wb_vld_q[i] && ((wb_dst_q[i] == rd_src1) || (wb_dst_q[i] == rd_src2))) begin
        hazard = 1'b1;
      end
    end
  end

  assign rd_req_ready = run & ~clear_req & ~full & ~hazard;
  assign wr_req_ready = run & ~full;
  assign rd_go        = rd_req_valid & rd_req_ready;
  assign push         = wr_req_valid & wr_req_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = CMD_IDLE;
    pop     = 1'b0;
    flush   = 1'b0;
    case (state_q)
      RUN: begin
        if (clear_req) begin
          state_d = CLEAR;
          cmd_d   = CMD_CLEAR;
          flush   = 1'b1;
        end else if (full) begin
          cmd_d = CMD_WRITE;
          pop   = 1'b1;
        end else if (rd_go) begin
          cmd_d = CMD_READ;
        end else if (!empty) begin
          cmd_d = CMD_WRITE;
          pop   = 1'b1;
        end
      end
      CLEAR:      state_d = CLEAR_DONE;
      CLEAR_DONE: state_d = RUN;
      default:    state_d = RUN;
    endcase
  end

  // A clear discards everything, including a write handed over on the same edge.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      wb_vld_q <= '0;
    end else begin
      if (push) begin
        wb_vld_q[tail_q] <= 1'b1;
        tail_q           <= tail_q + 1'b1;
      end
      if (pop) begin
        wb_vld_q[head_q] <= 1'b0;
        head_q           <= head_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      wb_dst_q[tail_q] <= wr_dst;
      wb_dat_q[tail_q] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rf_read            <= 1'b0;
      rf_write           <= 1'b0;
      rf_reset           <= 1'b0;
      rf_enable          <= 1'b0;
      rf_in              <= '0;
      rf_select_input    <= '0;
      rf_select_output_1 <= '0;
      rf_select_output_2 <= '0;
      rd_resp_valid      <= 1'b0;
      clear_ack          <= 1'b0;
    end else begin
      rf_read       <= (cmd_d == CMD_READ);
      rf_write      <= (cmd_d == CMD_WRITE);
      rf_reset      <= (cmd_d == CMD_CLEAR);
      rf_enable     <= (cmd_d != CMD_IDLE);
      rd_resp_valid <= rf_read;
      clear_ack     <= (state_q == CLEAR_DONE);
      if (cmd_d == CMD_READ) begin
        rf_select_output_1 <= rd_src1;
        rf_select_output_2 <= rd_src2;
      end
      if (cmd_d == CMD_WRITE) begin
        rf_select_input <= wb_dst_q[head_q];
        rf_in           <= wb_dat_q[head_q];
      end
    end
  end

  assign rd_data1 = rf_data_1;
  assign rd_data2 = rf_data_2;
  assign wb_count = count_q;

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Bench for regfile_access_sequencer: queue-based command model plus a register-file model.
module tb_regfile_access_sequencer;
  localparam int D = 4, DW = 32, AW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rd_req_valid = 1'b0, rd_req_ready;
  logic [AW-1:0] rd_src1 = '0, rd_src2 = '0;
  logic          rd_resp_valid;
  logic [DW-1:0] rd_data1, rd_data2;
  logic          wr_req_valid = 1'b0, wr_req_ready;
  logic [AW-1:0] wr_dst = '0;
  logic [DW-1:0] wr_data = '0;
  logic          clear_req = 1'b0, clear_ack;
  logic [2:0]    wb_count;
  logic [DW-1:0] rf_in;
  logic [AW-1:0] rf_select_input, rf_select_output_1, rf_select_output_2;
  logic          rf_read, rf_write, rf_enable, rf_reset;
  logic [DW-1:0] rf_data_1 = '0, rf_data_2 = '0;

  always #5 clock = ~clock;

  regfile_access_sequencer #(.WB_DEPTH(D), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_src1(rd_src1), .rd_src2(rd_src2),
    .rd_resp_valid(rd_resp_valid), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_dst(wr_dst), .wr_data(wr_data),
    .clear_req(clear_req), .clear_ack(clear_ack), .wb_count(wb_count),
    .rf_in(rf_in), .rf_select_input(rf_select_input),
    .rf_select_output_1(rf_select_output_1), .rf_select_output_2(rf_select_output_2),
    .rf_read(rf_read), .rf_write(rf_write), .rf_enable(rf_enable), .rf_reset(rf_reset),
    .rf_data_1(rf_data_1), .rf_data_2(rf_data_2)
  );

  // Register file: read has priority over write, outputs are registered.
  logic [DW-1:0] rf_mem [32] = '{default: '0};
  always @(posedge clock) begin
    if (rf_enable === 1'b1) begin
      if (rf_read) begin
        rf_data_1 <= rf_mem[rf_select_output_1];
        rf_data_2 <= rf_mem[rf_select_output_2];
      end else if (rf_write) begin
        rf_mem[rf_select_input] <= rf_in;
      end
      if (rf_reset) for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
    end
  end

  typedef struct packed { logic [AW-1:0] dst; logic [DW-1:0] dat; } wr_t;
  wr_t           wq [$];
  logic [DW-1:0] mmem [32] = '{default: '0};
  int            mstate = 0;   // 0 run, 1 clear, 2 clear done
  int            mcmd = 0;     // 0 idle, 1 read, 2 write, 3 clear
  logic [AW-1:0] m_s1 = '0, m_s2 = '0, m_wd = '0;
  logic [DW-1:0] m_wdat = '0, m_r1 = '0, m_r2 = '0;
  bit            m_resp_v = 0, m_ack = 0, model_ok = 0;

  int checks = 0, errors = 0;
  logic          obs_rr, obs_wr, obs_rv, obs_ack, obs_rfr;
  logic [2:0]    obs_cnt;
  logic [DW-1:0] obs_d1, obs_d2;
  logic          first_wr;
  logic [2:0]    first_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit hazard(input logic [AW-1:0] a, input logic [AW-1:0] b);
    foreach (wq[i]) if (wq[i].dst == a || wq[i].dst == b) return 1;
    return 0;
  endfunction

  // One clock cycle: drive, compare against the model, advance the model at the edge.
  task automatic step(input bit rv, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                      input bit wv, input logic [AW-1:0] wd, input logic [DW-1:0] wdat,
                      input bit clr, input bit rst);
    bit exp_rr, exp_wr, full, ack_n;
    logic [DW-1:0] c1, c2;
    wr_t e, n;
    rd_req_valid = rv; rd_src1 = s1; rd_src2 = s2;
    wr_req_valid = wv; wr_dst = wd; wr_data = wdat;
    clear_req = clr; reset = rst;
    #1;
    obs_rr = rd_req_ready; obs_wr = wr_req_ready; obs_cnt = wb_count; obs_rv = rd_resp_valid;
    obs_d1 = rd_data1; obs_d2 = rd_data2; obs_ack = clear_ack; obs_rfr = rf_reset;
    full   = (wq.size() == D);
    exp_wr = (mstate == 0) && !full;
    exp_rr = exp_wr && !clr && !hazard(s1, s2);
    if (model_ok) begin
      chk("rd_req_ready", obs_rr, exp_rr);
      chk("wr_req_ready", obs_wr, exp_wr);
      chk("wb_count", obs_cnt, wq.size());
      chk("clear_ack", obs_ack, m_ack);
      chk("rf_read", rf_read, mcmd == 1);
      chk("rf_write", rf_write, mcmd == 2);
      chk("rf_reset", obs_rfr, mcmd == 3);
      chk("rf_enable", rf_enable, mcmd != 0);
      chk("rd_resp_valid", obs_rv, m_resp_v);
      if (m_resp_v) begin
        chk("rd_data1", obs_d1, m_r1);
        chk("rd_data2", obs_d2, m_r2);
      end
      if (mcmd == 1) begin
        chk("rf_select_output_1", rf_select_output_1, m_s1);
        chk("rf_select_output_2", rf_select_output_2, m_s2);
      end
      if (mcmd == 2) begin
        chk("rf_select_input", rf_select_input, m_wd);
        chk("rf_in", rf_in, m_wdat);
      end
    end
    @(posedge clock);
    c1 = '0; c2 = '0;
    case (mcmd)
      1: begin c1 = mmem[m_s1]; c2 = mmem[m_s2]; end
      2: mmem[m_wd] = m_wdat;
      3: for (int i = 0; i < 32; i++) mmem[i] = '0;
      default: ;
    endcase
    m_resp_v = (mcmd == 1) && !rst;
    m_r1 = c1; m_r2 = c2;
    ack_n = (mstate == 2) && !rst;
    m_ack = ack_n;
    mcmd = 0;
    if (rst) begin
      mstate = 0; wq.delete(); model_ok = 1;
    end else if (mstate == 0) begin
      if (clr) begin
        mcmd = 3; mstate = 1; wq.delete();
      end else begin
        if (full || !(rv && exp_rr) && wq.size() > 0) begin
          e = wq.pop_front(); mcmd = 2; m_wd = e.dst; m_wdat = e.dat;
        end else if (rv && exp_rr) begin
          mcmd = 1; m_s1 = s1; m_s2 = s2;
        end
        if (wv && exp_wr) begin
          n.dst = wd; n.dat = wdat; wq.push_back(n);
        end
      end
    end else begin
      mstate = (mstate == 1) ? 2 : 0;
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, '0, '0, 0, '0, '0, 0, 0);
  endtask

  task automatic write_one(input logic [AW-1:0] d, input logic [DW-1:0] v,
                           input bit hold_rd, input logic [AW-1:0] rs);
    bit done = 0;
    for (int k = 0; k < 20; k++) begin
      step(hold_rd, rs, rs, 1, d, v, 0, 0);
      if (k == 0) begin first_wr = obs_wr; first_cnt = obs_cnt; end
      if (obs_wr) begin done = 1; break; end
    end
    chk("write accepted in time", done, 1);
  endtask

  task automatic read_pair(input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [DW-1:0] e1, input logic [DW-1:0] e2, input string nm);
    bit done = 0;
    for (int k = 0; k < 20; k++) begin
      step(1, a, b, 0, '0, '0, 0, 0);
      if (obs_rr) begin done = 1; break; end
    end
    chk({nm, " accepted"}, done, 1);
    idle(1);
    chk({nm, " no early resp"}, obs_rv, 0);
    idle(1);
    chk({nm, " resp_valid"}, obs_rv, 1);
    chk({nm, " data1"}, obs_d1, e1);
    chk({nm, " data2"}, obs_d2, e2);
  endtask

  initial begin
    @(negedge clock);
    for (int k = 0; k < 3; k++) step(0, '0, '0, 0, '0, '0, 0, 1);
    idle(1);
    chk("reset wb_count", obs_cnt, 0);
    chk("reset wr_req_ready", obs_wr, 1);
    chk("reset rd_resp_valid", obs_rv, 0);
    chk("reset clear_ack", obs_ack, 0);
    chk("reset rf_enable", rf_enable, 0);

    read_pair(3, 7, 0, 0, "r3r7");

    write_one(5, 32'hDEADBEEF, 0, '0);
    step(1, 5, 0, 0, '0, '0, 0, 0);
    chk("hazard stall", obs_rr, 0);
    read_pair(5, 0, 32'hDEADBEEF, 0, "r5r0");

    for (int i = 1; i <= 5; i++) write_one(AW'(i), 32'h100 + i, 1, 9);
    chk("full wb_count", first_cnt, 4);
    chk("full wr_req_ready", first_wr, 0);
    idle(8);
    read_pair(1, 2, 32'h101, 32'h102, "r1r2");
    read_pair(3, 4, 32'h103, 32'h104, "r3r4");
    read_pair(5, 5, 32'h105, 32'h105, "r5r5");

    write_one(2, 32'h11, 0, '0);
    idle(3);
    step(1, 2, 2, 1, 2, 32'h22, 0, 0);
    chk("same-edge read accepted", obs_rr, 1);
    idle(2);
    chk("same-edge old data", obs_d1, 32'h11);
    idle(2);
    read_pair(2, 2, 32'h22, 32'h22, "r2 new");

    write_one(10, 32'hA0, 1, 9);
    write_one(11, 32'hA1, 1, 9);
    write_one(12, 32'hA2, 1, 9);
    step(0, '0, '0, 0, '0, '0, 1, 0);
    chk("pre-clear wb_count", obs_cnt, 3);
    idle(1);
    chk("clear rf_reset", obs_rfr, 1);
    chk("clear wb_count", obs_cnt, 0);
    idle(1);
    chk("clear_ack not yet", obs_ack, 0);
    idle(1);
    chk("clear_ack", obs_ack, 1);
    read_pair(10, 11, 0, 0, "post-clear r10r11");
    read_pair(12, 5, 0, 0, "post-clear r12r5");

    step(1, 9, 9, 1, 20, 32'hAAAA, 0, 0);
    step(1, 9, 9, 1, 21, 32'hBBBB, 0, 0);
    step(0, '0, '0, 0, '0, '0, 0, 1);
    idle(1);
    chk("reset suppresses resp", obs_rv, 0);
    chk("reset empties buffer", obs_cnt, 0);
    idle(3);
    read_pair(20, 21, 0, 0, "dropped writes");

    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 1), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
           $urandom_range(0, 9) < 4, AW'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 63) == 0, $urandom_range(0, 199) == 0);
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
